wb_master_arbiter: RTL and testbench
====================================

# wb_master_arbiter

Parametrised Wishbone (classic) arbiter that merges `NUM_MASTERS` master ports onto one slave port, e.g. a core's instruction and data buses onto a single memory/Controller bus. It generalises the fixed two-bus core hookup. It adds:
- selectable round-robin or fixed-priority arbitration;
- grant locking for the whole `cyc` window;
- a per-transaction timeout watchdog that returns a Wishbone error instead of hanging the core.

## Interface
- `NUM_MASTERS`, 2: number of master ports, 2..8.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width, multiple of 8; `SEL_WIDTH = DATA_WIDTH/8`.
- `PRIORITY_MODE`, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.
- `TIMEOUT_CYCLES`, 255: stalled-strobe cycles before an error is returned; 0 disables the watchdog.

- `sys_clk`  in  1  system clock, all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `m_cyc_i`  in  NUM_MASTERS  per-master cycle.
- `m_stb_i`  in  NUM_MASTERS  per-master strobe.
- `m_we_i`  in  NUM_MASTERS  per-master write enable.
- `m_sel_i`  in  NUM_MASTERS*SEL_WIDTH  byte selects, master i at slice [i*SEL_WIDTH +: SEL_WIDTH].
- `m_addr_i`  in  NUM_MASTERS*ADDR_WIDTH  addresses, packed the same way.
- `m_data_i`  in  NUM_MASTERS*DATA_WIDTH  write data, packed the same way.
- `m_data_o`  out  DATA_WIDTH  read data, broadcast to all masters.
- `m_ack_o`  out  NUM_MASTERS  per-master acknowledge.
- `m_err_o`  out  NUM_MASTERS  per-master error.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  slave cycle, strobe and write enable.
- `s_sel_o`  out  SEL_WIDTH  slave byte selects.
- `s_addr_o`  out  ADDR_WIDTH  slave address.
- `s_data_o`  out  DATA_WIDTH  slave write data.
- `s_data_i`  in  DATA_WIDTH  slave read data.
- `s_ack_i`, `s_err_i`  in  1  slave acknowledge and error.
- `grant_o`  out  NUM_MASTERS  one-hot current owner; all zero when idle.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.

## Operation
State machine states: IDLE, GRANTED, ABORT.
- **IDLE**
  - All slave outputs are 0 and all `m_ack_o`/`m_err_o` are 0.
  - If any `m_cyc_i` bit is set, select the winner and register it into a one-hot grant; move to GRANTED.
  - Round-robin: search starts at the index after the last granted master and wraps modulo NUM_MASTERS.
  - Fixed priority: lowest set index wins.
- **GRANTED**
  - The granted master's cyc/stb/we/sel/addr/data drive the slave port combinationally.
  - `m_data_o = s_data_i` always.
  - `m_ack_o[g] = s_ack_i`, `m_err_o[g] = s_err_i`; non-granted masters see 0.
  - The grant is held while `m_cyc_i[g]` is 1, including cycles with `stb` low, so lock/RMW sequences are atomic.
  - When `m_cyc_i[g]` falls: go to IDLE and set the round-robin pointer to g.
- **Watchdog**
  - The counter increments each GRANTED cycle in which `s_stb_o` = 1 and `s_ack_i` = `s_err_i` = 0.
  - It clears on ack, on err, when stb is low, and on any state change.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
  - When the count equals TIMEOUT_CYCLES, move to ABORT.
- **ABORT** (exactly one cycle)
  - `m_err_o[g]` = 1, `timeout_o` = 1.
  - `s_cyc_o` = `s_stb_o` = 0.
  - Next state is GRANTED if `m_cyc_i[g]` is still 1, else IDLE. The grant is unchanged.
- A slave ack or err that arrives during ABORT is ignored and not forwarded.

## Timing
- Reset (async assert, synchronous release) gives: state IDLE, grant 0, round-robin pointer 0, counter 0. All outputs are 0; `m_data_o` follows `s_data_i`.
- Arbitration latency is 1 cycle: a request in cycle N is granted and visible on the slave port in cycle N+1.
- Ack/err/data path from slave to master is combinational, 0 cycles.
- There is one dead IDLE cycle between consecutive grants, even when another master is waiting.
- Simultaneous ack and timeout threshold in the same cycle: ack wins, no error, counter clears.
- Simultaneous requests: the winner is decided solely by the mode and pointer. A non-granted master's request is held off (no ack) indefinitely until granted.
- Reset asserted mid-transfer drops `s_cyc_o` immediately and no ack is produced.
- With TIMEOUT_CYCLES = 0, ABORT is unreachable and `timeout_o` stays 0.

## Test plan
- **Single master:** m0 reads addr 0x100, slave acks 2 cycles later with 0xDEADBEEF. Required: `s_cyc_o` rises 1 cycle after `m_cyc_i[0]`; `m_ack_o[0]` is coincident with `s_ack_i`; `m_data_o` = 0xDEADBEEF; `grant_o` = 01.
- **Round-robin:** m0 and m1 both request continuously, each releasing cyc after its ack. Required: grant order 0,1,0,1 with exactly one IDLE cycle between grants.
- **Fixed priority** (PRIORITY_MODE = 1, NUM_MASTERS = 3): m1 and m2 request; then m0 requests while m1 is granted. Required: m1 first, then m0, then m2; m1 is never pre-empted while its cyc is high.
- **Grant lock:** m0 holds cyc with stb low for 5 cycles while m1 requests. Required: `grant_o` stays 01; m1 receives no ack until m0 drops cyc.
- **Timeout** (TIMEOUT_CYCLES = 4): slave never acks. Required: after 4 stalled cycles, ABORT fires; `m_err_o[0]` and `timeout_o` are high for 1 cycle; `s_cyc_o` is 0 in that cycle. With an ack on the 4th cycle, no error is produced.
- **Async reset mid-transfer:** `rst_n` goes low while granted with stb high. Required: all slave outputs and `grant_o` are 0 immediately; after release, the first grant in round-robin mode goes to the lowest requesting index.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: merges NUM_MASTERS Wishbone classic masters onto one slave port,
// with round-robin or fixed-priority arbitration, cyc-long grant locking and a stall watchdog.
module wb_master_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                   sys_clk,
    input  logic                                   rst_n,
    input  logic [NUM_MASTERS-1:0]                 m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                 m_stb_i,
    input  logic [NUM_MASTERS-1:0]                 m_we_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]  m_sel_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_data_i,
    output logic [DATA_WIDTH-1:0]                  m_data_o,
    output logic [NUM_MASTERS-1:0]                 m_ack_o,
    output logic [NUM_MASTERS-1:0]                 m_err_o,
    output logic                                   s_cyc_o,
    output logic                                   s_stb_o,
    output logic                                   s_we_o,
    output logic [DATA_WIDTH/8-1:0]                s_sel_o,
    output logic [ADDR_WIDTH-1:0]                  s_addr_o,
    output logic [DATA_WIDTH-1:0]                  s_data_o,
    input  logic [DATA_WIDTH-1:0]                  s_data_i,
    input  logic                                   s_ack_i,
    input  logic                                   s_err_i,
    output logic [NUM_MASTERS-1:0]                 grant_o,
    output logic                                   timeout_o
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, GRANTED, ABORT} state_t;

    state_t                 state, state_nx;
    logic [NUM_MASTERS-1:0] grant, grant_nx;
    logic [IW-1:0]          gidx, gidx_nx, ptr, ptr_nx, win;
    logic                   rr_valid, rr_valid_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic                   g_cyc, g_stb, granted, stall;

    assign g_cyc   = m_cyc_i[gidx];
    assign g_stb   = m_stb_i[gidx];
    assign granted = state == GRANTED;
    assign stall   = granted && g_stb && !s_ack_i && !s_err_i;

    // Until a first grant has been released the search starts at index 0.
    always_comb begin
        int            start;
        logic [IW-1:0] idx;
        logic          found;
        start = (PRIORITY_MODE == 0 && rr_valid) ? (int'(ptr) + 1) % NUM_MASTERS : 0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = IW'((start + i) % NUM_MASTERS);
            if (!found && m_cyc_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        gidx_nx     = gidx;
        ptr_nx      = ptr;
        rr_valid_nx = rr_valid;
        cnt_nx      = '0;
        if (state == IDLE) begin
            if (|m_cyc_i) begin
                state_nx = GRANTED;
                gidx_nx  = win;
                grant_nx = NUM_MASTERS'(1) << win;
            end
        end else if (!g_cyc) begin
            state_nx    = IDLE;
            grant_nx    = '0;
            ptr_nx      = gidx;
            rr_valid_nx = 1'b1;
        end else if (state == ABORT) begin
            state_nx = GRANTED;
        end else if (stall) begin
            if (TIMEOUT_CYCLES != 0 && cnt == LAST) state_nx = ABORT;
            else cnt_nx = cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            gidx     <= '0;
            ptr      <= '0;
            rr_valid <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            gidx     <= gidx_nx;
            ptr      <= ptr_nx;
            rr_valid <= rr_valid_nx;
            cnt      <= cnt_nx;
        end
    end

    assign s_cyc_o   = granted & g_cyc;
    assign s_stb_o   = granted & g_stb;
    assign s_we_o    = granted & m_we_i[gidx];
    assign s_sel_o   = granted ? m_sel_i[gidx*SW +: SW] : '0;
    assign s_addr_o  = granted ? m_addr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s_data_o  = granted ? m_data_i[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_data_o  = s_data_i;
    assign m_ack_o   = (granted && s_ack_i) ? grant : '0;
    assign m_err_o   = ((granted && s_err_i) || state == ABORT) ? grant : '0;
    assign grant_o   = grant;
    assign timeout_o = state == ABORT;
endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: directed checks of a 2-master round-robin arbiter with a 4-cycle watchdog
// and a 3-master fixed-priority arbiter with the watchdog disabled.
module tb_wb_master_arbiter;
    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [1:0]  a_cyc = '0, a_stb = '0, a_we = '0, a_ack, a_err, a_gnt;
    logic [7:0]  a_sel = '0;
    logic [63:0] a_addr = '0, a_wdat = '0;
    logic [31:0] a_rdat, as_addr, as_dat, a_sdat = '0;
    logic        as_cyc, as_stb, as_we, a_sack = 1'b0, a_serr = 1'b0, a_to;
    logic [3:0]  as_sel;

    logic [2:0]  b_cyc = '0, b_stb = '0, b_we = '0, b_ack, b_err, b_gnt;
    logic [11:0] b_sel = '0;
    logic [95:0] b_addr = '0, b_wdat = '0;
    logic [31:0] b_rdat, bs_addr, bs_dat, b_sdat = '0;
    logic        bs_cyc, bs_stb, bs_we, b_sack = 1'b0, b_serr = 1'b0, b_to;
    logic [3:0]  bs_sel;

    int         checks = 0, errors = 0;
    logic [1:0] e;
    logic       any_to;

    wb_master_arbiter #(.NUM_MASTERS(2), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)) u_rr (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .m_cyc_i(a_cyc), .m_stb_i(a_stb), .m_we_i(a_we), .m_sel_i(a_sel),
        .m_addr_i(a_addr), .m_data_i(a_wdat), .m_data_o(a_rdat),
        .m_ack_o(a_ack), .m_err_o(a_err),
        .s_cyc_o(as_cyc), .s_stb_o(as_stb), .s_we_o(as_we), .s_sel_o(as_sel),
        .s_addr_o(as_addr), .s_data_o(as_dat), .s_data_i(a_sdat),
        .s_ack_i(a_sack), .s_err_i(a_serr), .grant_o(a_gnt), .timeout_o(a_to)
    );

    wb_master_arbiter #(.NUM_MASTERS(3), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)) u_fp (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we), .m_sel_i(b_sel),
        .m_addr_i(b_addr), .m_data_i(b_wdat), .m_data_o(b_rdat),
        .m_ack_o(b_ack), .m_err_o(b_err),
        .s_cyc_o(bs_cyc), .s_stb_o(bs_stb), .s_we_o(bs_we), .s_sel_o(bs_sel),
        .s_addr_o(bs_addr), .s_data_o(bs_dat), .s_data_i(b_sdat),
        .s_ack_i(b_sack), .s_err_i(b_serr), .grant_o(b_gnt), .timeout_o(b_to)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #12;
        a_sdat = 32'h1234;
        #1;
        chk("rst_gnt", a_gnt, 0);
        chk("rst_scyc", as_cyc, 0);
        chk("rst_rdata", a_rdat, 32'h1234);
        chk("rst_to", a_to, 0);
        chk("rst_fp_gnt", b_gnt, 0);
        tick;
        rst_n = 1'b1;

        // single master read, acked two cycles after the grant
        tick;
        a_cyc = 2'b01; a_stb = 2'b01; a_addr[31:0] = 32'h100;
        #1 chk("t1_pre_cyc", as_cyc, 0);
        tick;
        chk("t1_cyc", as_cyc, 1);
        chk("t1_gnt", a_gnt, 2'b01);
        chk("t1_addr", as_addr, 32'h100);
        tick;
        chk("t1_wait", a_ack, 0);
        tick;
        a_sack = 1'b1; a_sdat = 32'hDEADBEEF;
        #1;
        chk("t1_ack", a_ack, 2'b01);
        chk("t1_data", a_rdat, 32'hDEADBEEF);
        chk("t1_err", a_err, 0);
        tick;
        a_sack = 1'b0; a_cyc = '0; a_stb = '0;
        #1 chk("t1_rel", as_cyc, 0);
        tick;
        chk("t1_idle", a_gnt, 0);

        // round-robin: last grant was m0, so m1 goes first
        a_cyc = 2'b11; a_stb = 2'b11;
        for (int k = 0; k < 4; k++) begin
            e = (k % 2 == 0) ? 2'b10 : 2'b01;
            tick;
            chk("rr_gnt", a_gnt, e);
            a_sack = 1'b1;
            #1 chk("rr_ack", a_ack, e);
            tick;
            a_sack = 1'b0; a_cyc = a_cyc & ~e; a_stb = a_stb & ~e;
            #1 chk("rr_drop", as_cyc, 0);
            tick;
            a_cyc = 2'b11; a_stb = 2'b11;
            #1 chk("rr_dead", a_gnt, 0);
        end
        a_cyc = '0; a_stb = '0;

        // grant lock: m0 holds cyc with stb low while m1 strobes
        a_cyc = 2'b01;
        tick;
        a_cyc = 2'b11; a_stb = 2'b10; a_we = 2'b10; a_sel[7:4] = 4'hC;
        a_addr[63:32] = 32'h200; a_wdat[63:32] = 32'hCAFEF00D;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("lock_gnt", a_gnt, 2'b01);
            chk("lock_ack", a_ack, 0);
            chk("lock_stb", as_stb, 0);
            tick;
        end
        a_cyc = 2'b10;
        #1 chk("lock_rel", as_cyc, 0);
        tick;
        chk("lock_dead", a_gnt, 0);
        tick;
        chk("lock_m1", a_gnt, 2'b10);
        chk("lock_we", as_we, 1);
        chk("lock_sel", as_sel, 4'hC);
        chk("lock_addr", as_addr, 32'h200);
        chk("lock_wdat", as_dat, 32'hCAFEF00D);
        a_sack = 1'b1;
        #1 chk("lock_ack1", a_ack, 2'b10);
        tick;
        a_sack = 1'b0; a_cyc = '0; a_stb = '0; a_we = '0;
        tick;

        // watchdog: four stalled cycles, then a one-cycle abort
        a_cyc = 2'b01; a_stb = 2'b01;
        tick;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("to_err_pre", a_err, 0);
            chk("to_pulse_pre", a_to, 0);
            tick;
        end
        a_sack = 1'b1;
        #1;
        chk("to_err", a_err, 2'b01);
        chk("to_pulse", a_to, 1);
        chk("to_scyc", as_cyc, 0);
        chk("to_sstb", as_stb, 0);
        chk("to_gnt", a_gnt, 2'b01);
        chk("to_ack_ign", a_ack, 0);
        tick;
        a_sack = 1'b0;
        #1;
        chk("to_back", as_cyc, 1);
        chk("to_pulse_end", a_to, 0);
        chk("to_err_end", a_err, 0);
        tick;
        tick;
        tick;
        a_sack = 1'b1;
        #1;
        chk("to_ack4", a_ack, 2'b01);
        chk("to_ack4_err", a_err, 0);
        tick;
        a_sack = 1'b0;
        #1;
        chk("to_ack4_noto", a_to, 0);
        chk("to_ack4_noerr", a_err, 0);
        chk("to_ack4_gnt", a_gnt, 2'b01);
        chk("to_ack4_cyc", as_cyc, 1);
        a_cyc = '0; a_stb = '0;
        tick;

        // async reset while granted with stb high
        a_cyc = 2'b01; a_stb = 2'b01;
        tick;
        chk("ar_pre", as_cyc, 1);
        a_sack = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("ar_cyc", as_cyc, 0);
        chk("ar_stb", as_stb, 0);
        chk("ar_gnt", a_gnt, 0);
        chk("ar_ack", a_ack, 0);
        a_sack = 1'b0; a_cyc = 2'b11; a_stb = 2'b11;
        tick;
        rst_n = 1'b1;
        tick;
        chk("ar_first", a_gnt, 2'b01);
        a_cyc = '0; a_stb = '0;
        tick;
        tick;

        // fixed priority, three masters, watchdog disabled
        b_cyc = 3'b110; b_stb = 3'b110; b_addr[95:64] = 32'h300;
        tick;
        chk("fp_first", b_gnt, 3'b010);
        b_cyc = 3'b111; b_stb = 3'b111;
        any_to = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            any_to |= b_to;
            chk("fp_hold", b_gnt, 3'b010);
            chk("fp_hold_ack", b_ack, 0);
            tick;
        end
        chk("fp_no_to", any_to, 0);
        b_sack = 1'b1;
        #1 chk("fp_ack1", b_ack, 3'b010);
        tick;
        b_sack = 1'b0; b_cyc = 3'b101; b_stb = 3'b101;
        tick;
        chk("fp_dead", b_gnt, 0);
        tick;
        chk("fp_second", b_gnt, 3'b001);
        b_sack = 1'b1;
        #1 chk("fp_ack0", b_ack, 3'b001);
        tick;
        b_sack = 1'b0; b_cyc = 3'b100; b_stb = 3'b100;
        tick;
        tick;
        chk("fp_third", b_gnt, 3'b100);
        chk("fp_addr2", bs_addr, 32'h300);
        b_sack = 1'b1;
        #1 chk("fp_ack2", b_ack, 3'b100);
        tick;
        b_sack = 1'b0; b_cyc = '0; b_stb = '0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
